// File: rtl/snake_pkg.sv
// Shared snake game definitions: grid size, cell status codes, default colours.
// Pure declarations, no latency.
// No flow control; used by the controller and the renderer.
package snake_pkg;

    localparam int GRID_W = 160;
    localparam int GRID_H = 120;
    localparam int XW     = 8;
    localparam int YW     = 7;
    localparam int AW     = XW + YW;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BODY  = 2'd1,
        ST_FOOD  = 2'd2,
        ST_HEAD  = 2'd3
    } status_e;

    localparam logic [2:0] C_EMPTY = 3'b000;
    localparam logic [2:0] C_BODY  = 3'b010;
    localparam logic [2:0] C_FOOD  = 3'b100;
    localparam logic [2:0] C_HEAD  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DRAIN,
        S_DONE
    } rstate_e;

    // One in-flight read: valid bit plus the pixel it belongs to.
    typedef struct packed {
        logic          vld;
        logic [XW-1:0] x;
        logic [YW-1:0] y;
    } pix_t;

    function automatic logic [2:0] colour_map(
        input logic [1:0] st,
        input logic [2:0] c_empty,
        input logic [2:0] c_body,
        input logic [2:0] c_food,
        input logic [2:0] c_head
    );
        logic [2:0] c;
        case (status_e'(st))
            ST_EMPTY: c = c_empty;
            ST_BODY:  c = c_body;
            ST_FOOD:  c = c_food;
            default:  c = c_head;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/snake_grid_renderer_if.sv
// Renderer bus: frame control, grid RAM read port and vga_adapter plot port.
// No latency of its own.
// No backpressure; the VGA side accepts one pixel per cycle.
interface snake_grid_renderer_if;
    import snake_pkg::*;

    logic          start;
    logic          busy;
    logic          done;
    logic [AW-1:0] ram_addr;
    logic [1:0]    ram_q;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic [2:0]    colour;
    logic          plot;

    modport master (
        input  start,
        input  ram_q,
        output busy,
        output done,
        output ram_addr,
        output x_out,
        output y_out,
        output colour,
        output plot
    );

    modport slave (
        output start,
        output ram_q,
        input  busy,
        input  done,
        input  ram_addr,
        input  x_out,
        input  y_out,
        input  colour,
        input  plot
    );

endinterface

// File: rtl/snake_raster_counter.sv
// Row-major x/y raster counter with clear, enable, compare-based wrap and last flag.
// last is combinational from the current count; the count moves one step per enabled cycle.
// No backpressure; the owner gates en.
module snake_raster_counter
    import snake_pkg::*;
#(
    parameter int W = GRID_W,
    parameter int H = GRID_H
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clr,
    input  logic          en,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic x_max;
    logic y_max;

    // Compare against the bound rather than relying on overflow, so any W/H fits.
    assign x_max = (x == XW'(W - 1));
    assign y_max = (y == YW'(H - 1));
    assign last  = x_max & y_max;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (clr) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x_max) begin
                x <= '0;
                y <= y_max ? '0 : y + 1'b1;
            end else begin
                x <= x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_grid_renderer.sv
// Raster-scans the snake grid RAM once per start and plots every cell as a coloured pixel.
// Latency: start in cycle 0 -> first plot in cycle READ_LATENCY+2, done after the last plot.
// No backpressure: one address and one pixel per cycle; start is ignored unless idle.
module snake_grid_renderer #(
    parameter int         GRID_W       = snake_pkg::GRID_W,
    parameter int         GRID_H       = snake_pkg::GRID_H,
    parameter int         READ_LATENCY = 1,
    parameter logic [2:0] C_EMPTY      = snake_pkg::C_EMPTY,
    parameter logic [2:0] C_BODY       = snake_pkg::C_BODY,
    parameter logic [2:0] C_FOOD       = snake_pkg::C_FOOD,
    parameter logic [2:0] C_HEAD       = snake_pkg::C_HEAD
) (
    input logic                   clk,
    input logic                   reset_n,
    snake_grid_renderer_if.master bus
);
    import snake_pkg::*;

    rstate_e       state_q;
    rstate_e       state_d;
    logic          cnt_clr;
    logic          issue;
    logic          cnt_last;
    logic [XW-1:0] cnt_x;
    logic [YW-1:0] cnt_y;
    logic          pipe_busy;

    pix_t          dly_q [READ_LATENCY];
    pix_t          tail;

    logic          plot_q;
    logic [XW-1:0] x_q;
    logic [YW-1:0] y_q;
    logic [2:0]    col_q;

    snake_raster_counter #(
        .W (GRID_W),
        .H (GRID_H)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cnt_clr),
        .en      (issue),
        .x       (cnt_x),
        .y       (cnt_y),
        .last    (cnt_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_clr = 1'b0;
        issue   = 1'b0;
        case (state_q)
            S_IDLE: begin
                cnt_clr = 1'b1;
                if (bus.start) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                issue = 1'b1;
                if (cnt_last) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!pipe_busy) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Coordinates travel alongside the read so they line up with ram_q at the tail.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= '{vld: issue, x: cnt_x, y: cnt_y};
            for (int i = 1; i < READ_LATENCY; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    assign tail = dly_q[READ_LATENCY-1];

    always_comb begin
        pipe_busy = 1'b0;
        for (int i = 0; i < READ_LATENCY; i++) begin
            pipe_busy = pipe_busy | dly_q[i].vld;
        end
    end

    // ram_q is only looked at when the tail carries a valid read.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            plot_q <= 1'b0;
            x_q    <= '0;
            y_q    <= '0;
            col_q  <= '0;
        end else begin
            plot_q <= tail.vld;
            if (tail.vld) begin
                x_q   <= tail.x;
                y_q   <= tail.y;
                col_q <= colour_map(bus.ram_q, C_EMPTY, C_BODY, C_FOOD, C_HEAD);
            end
        end
    end

    assign bus.ram_addr = issue ? {cnt_x, cnt_y} : '0;
    assign bus.x_out    = x_q;
    assign bus.y_out    = y_q;
    assign bus.colour   = col_q;
    assign bus.plot     = plot_q;
    assign bus.busy     = (state_q == S_SCAN) || (state_q == S_DRAIN);
    assign bus.done     = (state_q == S_DONE);

endmodule
